// File: rtl/alu_writeback.sv
// ALU retire stage: in-order result queue, register-file write arbitration,
// in-order status commit, branch condition evaluation and pending-write mask.
module alu_writeback #(
    parameter int DEPTH  = 2,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_result,
    input  logic [3:0]             in_flags,
    input  logic [REG_AW-1:0]      in_rd,
    input  logic                   in_wr_en,
    input  logic                   in_flag_en,
    output logic                   rf_we,
    output logic [REG_AW-1:0]      rf_waddr,
    output logic [7:0]             rf_wdata,
    input  logic                   rf_grant,
    output logic [3:0]             status,
    output logic                   flags_busy,
    input  logic [3:0]             cond_sel,
    output logic                   cond_true,
    output logic [2**REG_AW-1:0]   pending_mask,
    output logic [CNT_W-1:0]       retire_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Entry payload; only meaningful where valid_q is set.
    logic [7:0]        data_q [DEPTH];
    logic [3:0]        flg_q  [DEPTH];
    logic [REG_AW-1:0] rd_q   [DEPTH];
    logic [DEPTH-1:0]  wr_q;
    logic [DEPTH-1:0]  fe_q;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [3:0]        status_q, status_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

    logic empty, push, retire;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign rf_we    = !empty && wr_q[head_q];
    assign rf_waddr = rd_q[head_q];
    assign rf_wdata = data_q[head_q];
    // A writing head waits for the port; a non-writing head leaves at once.
    assign retire   = !empty && (!wr_q[head_q] || rf_grant);

    assign status     = status_q;
    assign retire_cnt = retire_cnt_q;

    // Capture the pushed entry at the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail_q] <= in_result;
            flg_q[tail_q]  <= in_flags;
            rd_q[tail_q]   <= in_rd;
            wr_q[tail_q]   <= in_wr_en;
            fe_q[tail_q]   <= in_flag_en;
        end
    end

    // Next-state for pointers, occupancy, status and retire counter.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        valid_d      = valid_q;
        status_d     = status_q;
        retire_cnt_d = retire_cnt_q;
        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
            retire_cnt_d    = retire_cnt_q + 1'b1;
            if (fe_q[head_q]) status_d = flg_q[head_q];
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
        end
        case ({push, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            status_q     <= '0;
            retire_cnt_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            status_q     <= status_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Scoreboard views over every occupied slot, including a retiring head.
    always_comb begin
        pending_mask = '0;
        flags_busy   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && wr_q[i]) pending_mask[rd_q[i]] = 1'b1;
            if (valid_q[i] && fe_q[i]) flags_busy = 1'b1;
        end
    end

    // Branch conditions on committed flags {N,V,C,Z}.
    always_comb begin
        logic n, v, c, z;
        n = status_q[3];
        v = status_q[2];
        c = status_q[1];
        z = status_q[0];
        cond_true = 1'b0;
        case (cond_sel)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = z;
            4'd2:    cond_true = !z;
            4'd3:    cond_true = c;
            4'd4:    cond_true = !c;
            4'd5:    cond_true = n;
            4'd6:    cond_true = !n;
            4'd7:    cond_true = v;
            4'd8:    cond_true = !v;
            4'd9:    cond_true = (n == v);
            4'd10:   cond_true = (n != v);
            4'd11:   cond_true = !z && (n == v);
            4'd12:   cond_true = z || (n != v);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback (DEPTH=2, REG_AW=3, CNT_W=16).
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_result;
    logic [3:0]  in_flags;
    logic [2:0]  in_rd;
    logic        in_wr_en;
    logic        in_flag_en;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic        rf_grant;
    logic [3:0]  status;
    logic        flags_busy;
    logic [3:0]  cond_sel;
    logic        cond_true;
    logic [7:0]  pending_mask;
    logic [15:0] retire_cnt;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_cnt;

    alu_writeback #(.DEPTH(2), .REG_AW(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd),
        .in_wr_en(in_wr_en), .in_flag_en(in_flag_en),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_grant(rf_grant), .status(status), .flags_busy(flags_busy),
        .cond_sel(cond_sel), .cond_true(cond_true),
        .pending_mask(pending_mask), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  st;
        logic [15:0] mask;
    } cond_vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] res, input logic [2:0] rd,
                         input logic we, input logic fe, input logic [3:0] fl);
        in_valid   = v;
        in_result  = res;
        in_rd      = rd;
        in_wr_en   = we;
        in_flag_en = fe;
        in_flags   = fl;
    endtask

    initial begin
        cond_vec_t tbl[4];
        tbl[0] = '{st: 4'b1000, mask: 16'h1535};   // N=1 V=0
        tbl[1] = '{st: 4'b1100, mask: 16'h0AB5};   // N=1 V=1 Z=0
        tbl[2] = '{st: 4'b0011, mask: 16'h134B};   // C=1 Z=1
        tbl[3] = '{st: 4'b0110, mask: 16'h14CD};   // V=1 C=1

        rst_n = 1'b0;
        rf_grant = 1'b0;
        cond_sel = 4'd0;
        drive(0, 8'h00, 3'd0, 0, 0, 4'h0);
        exp_cnt = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_rf_we", rf_we, 0);
        check("rst_status", status, 0);
        check("rst_cnt", retire_cnt, 0);
        check("rst_busy", flags_busy, 0);
        check("rst_pending", pending_mask, 0);
        rst_n = 1'b1;
        tick();

        // Single write with grant tied high.
        rf_grant = 1'b1;
        drive(1, 8'h5A, 3'd3, 1, 1, 4'b0000);
        tick();
        drive(0, 8'h00, 3'd0, 0, 0, 4'h0);
        check("t1_rf_we", rf_we, 1);
        check("t1_waddr", rf_waddr, 3);
        check("t1_wdata", rf_wdata, 8'h5A);
        check("t1_pending", pending_mask, 8'h08);
        check("t1_busy", flags_busy, 1);
        tick();
        exp_cnt++;
        check("t1_rf_we_after", rf_we, 0);
        check("t1_pending_after", pending_mask, 0);
        check("t1_status", status, 0);
        check("t1_cnt", retire_cnt, exp_cnt);

        // Backpressure: three writes, port withheld.
        rf_grant = 1'b0;
        drive(1, 8'h11, 3'd1, 1, 0, 4'hF);
        tick();
        check("bp_ready_1", in_ready, 1);
        drive(1, 8'h22, 3'd2, 1, 0, 4'hF);
        tick();
        check("bp_ready_full", in_ready, 0);
        drive(1, 8'h33, 3'd3, 1, 0, 4'hF);
        tick();
        tick();
        check("bp_ready_held", in_ready, 0);
        check("bp_rf_we", rf_we, 1);
        check("bp_waddr_stable", rf_waddr, 1);
        check("bp_wdata_stable", rf_wdata, 8'h11);
        check("bp_pending", pending_mask, 8'h06);
        rf_grant = 1'b1;
        tick();
        rf_grant = 1'b0;
        exp_cnt++;
        check("bp_head2_waddr", rf_waddr, 2);
        check("bp_head2_wdata", rf_wdata, 8'h22);
        check("bp_ready_after_pop", in_ready, 1);
        tick();
        drive(0, 8'h00, 3'd0, 0, 0, 4'h0);
        check("bp_third_accepted", in_ready, 0);
        check("bp_pending2", pending_mask, 8'h0C);
        rf_grant = 1'b1;
        tick();
        rf_grant = 1'b0;
        exp_cnt++;
        check("bp_head3_waddr", rf_waddr, 3);
        check("bp_head3_wdata", rf_wdata, 8'h33);
        rf_grant = 1'b1;
        tick();
        rf_grant = 1'b0;
        exp_cnt++;
        check("bp_empty_we", rf_we, 0);
        check("bp_cnt", retire_cnt, exp_cnt);
        check("bp_status_hold", status, 0);

        // Flag commit order; grant low to show non-writing entries ignore it.
        drive(1, 8'h00, 3'd0, 0, 1, 4'b0011);
        tick();
        check("fc_busy_1", flags_busy, 1);
        check("fc_rf_we", rf_we, 0);
        check("fc_status_pre", status, 0);
        drive(1, 8'h00, 3'd0, 0, 0, 4'b1000);
        tick();
        drive(0, 8'h00, 3'd0, 0, 0, 4'h0);
        exp_cnt++;
        check("fc_status_1", status, 4'b0011);
        check("fc_busy_2", flags_busy, 0);
        check("fc_rf_we_2", rf_we, 0);
        tick();
        exp_cnt++;
        check("fc_status_2", status, 4'b0011);
        check("fc_cnt", retire_cnt, exp_cnt);
        check("fc_empty", in_ready, 1);

        // Condition table from committed status.
        for (int r = 0; r < 4; r++) begin
            drive(1, 8'h00, 3'd0, 0, 1, tbl[r].st);
            tick();
            drive(0, 8'h00, 3'd0, 0, 0, 4'h0);
            tick();
            exp_cnt++;
            check("ct_status", status, tbl[r].st);
            check("ct_busy", flags_busy, 0);
            for (int s = 0; s < 16; s++) begin
                cond_sel = 4'(s);
                #1;
                check($sformatf("ct_st%0h_sel%0d", tbl[r].st, s), cond_true, tbl[r].mask[s]);
            end
        end

        // Full queue: grant and push in the same cycle, push refused.
        drive(1, 8'h44, 3'd4, 1, 0, 4'h0);
        tick();
        drive(1, 8'h55, 3'd5, 1, 0, 4'h0);
        tick();
        drive(1, 8'h66, 3'd6, 1, 0, 4'h0);
        check("fq_ready", in_ready, 0);
        rf_grant = 1'b1;
        tick();
        drive(0, 8'h00, 3'd0, 0, 0, 4'h0);
        exp_cnt++;
        check("fq_one_left", in_ready, 1);
        check("fq_head_waddr", rf_waddr, 5);
        check("fq_head_wdata", rf_wdata, 8'h55);
        check("fq_pending", pending_mask, 8'h20);
        tick();
        rf_grant = 1'b0;
        exp_cnt++;
        check("fq_empty_we", rf_we, 0);
        check("fq_empty_pending", pending_mask, 0);
        check("fq_cnt", retire_cnt, exp_cnt);

        // Asynchronous reset while the head waits for grant.
        drive(1, 8'h77, 3'd7, 1, 1, 4'hF);
        tick();
        drive(0, 8'h00, 3'd0, 0, 0, 4'h0);
        check("ar_we_pre", rf_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_we_async", rf_we, 0);
        check("ar_pending", pending_mask, 0);
        check("ar_busy", flags_busy, 0);
        check("ar_cnt", retire_cnt, 0);
        check("ar_status", status, 0);
        check("ar_ready", in_ready, 1);
        #2 rst_n = 1'b1;
        exp_cnt = '0;
        tick();
        check("ar_still_empty", rf_we, 0);

        // Retire-counter wrap via a stream of non-writing entries.
        drive(1, 8'h00, 3'd0, 0, 0, 4'h0);
        for (int k = 0; k < 65536; k++) tick();
        check("wrap_pre", retire_cnt, 16'hFFFF);
        drive(0, 8'h00, 3'd0, 0, 0, 4'h0);
        tick();
        check("wrap_zero", retire_cnt, 16'h0000);
        check("wrap_empty", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Execute-stage retire block directly downstream of the 8-bit ALU.
- Accepts each ALU result with its Z/C/V/N flags, destination register and enables through a valid/ready handshake, and buffers it in a small in-order queue.
- Arbitrates for the shared register-file write port, and commits the status register in program order.
- Provides condition evaluation for the branch unit and a pending-write mask for the issue scoreboard.

Parameters:
- DEPTH, 2: queue entries; legal values 2..4.
- REG_AW, 3: register address width; the register file has 2^REG_AW registers.
- CNT_W, 16: width of the retire counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  queue can accept an entry.
- in_result  input  8  ALU result.
- in_flags  input  4  flags from the ALU: {N,V,C,Z}, with Z in bit 0.
- in_rd  input  REG_AW  destination register.
- in_wr_en  input  1  entry writes the register file.
- in_flag_en  input  1  entry updates the status register.
- rf_we  output  1  register-file write request.
- rf_waddr  output  REG_AW  write address.
- rf_wdata  output  8  write data.
- rf_grant  input  1  register-file port granted this cycle.
- status  output  4  committed flags {N,V,C,Z}.
- flags_busy  output  1  a queued entry has in_flag_en=1.
- cond_sel  input  4  branch condition select.
- cond_true  output  1  selected condition evaluated on status.
- pending_mask  output  2^REG_AW  bit r set while any queued entry has wr_en=1 and rd=r.
- retire_cnt  output  CNT_W  count of retired entries.

Behaviour:
- Reset (asynchronous, rst_n=0): queue empty, status=0, retire_cnt=0, rf_we=0, flags_busy=0, pending_mask=0, in_ready=1. Reset asserted mid-operation discards all queued entries, including a head whose rf_we is waiting for grant.
- Push:
  - An entry is pushed on a rising edge with in_valid && in_ready.
  - in_ready = (count < DEPTH), computed from registered count only; it never depends on rf_grant.
  - When full, in_ready=0 even in a cycle where a pop occurs.
- Queue order: strictly FIFO. Head and tail pointers wrap modulo DEPTH.
- Outputs from the head: rf_we, rf_waddr and rf_wdata are driven from the head entry only. There is no combinational path from in_* to rf_*.
- Minimum latency: accepted at edge T, rf_we visible in the cycle after edge T.
- Head retire rules:
  - Head wr_en=1: rf_we=1 and is held, with stable address and data, until rf_grant=1. The head retires at that edge.
  - Head wr_en=0: rf_we=0 and the head retires at the next edge unconditionally.
  - rf_grant while rf_we=0 is ignored.
- On retire:
  - If flag_en=1, status <= head flags at the same edge. If flag_en=0, status holds.
  - retire_cnt increments, wrapping from 2^CNT_W-1 to 0.
- Simultaneous push and retire in the same cycle: count is unchanged and both pointers advance.
- Empty queue: rf_we=0 and no retire.
- flags_busy and pending_mask are combinational over valid queue entries.
  - A retiring entry still counts during its retire cycle.
  - A pushing entry counts from the next cycle.
- cond_true (combinational from status; N,V,C,Z name the status bits):
  - 0: always 1.
  - 1 EQ: Z. 2 NE: !Z.
  - 3 CS: C. 4 CC: !C.
  - 5 MI: N. 6 PL: !N.
  - 7 VS: V. 8 VC: !V.
  - 9 GE: N==V. 10 LT: N!=V.
  - 11 GT: !Z && N==V. 12 LE: Z || N!=V.
  - 13-15: 0.
- Branch-unit contract: cond_true is valid only when flags_busy=0. The block does not stall branches itself.
- Widths: data is 8-bit with no extension. Flags are passed through unmodified.

Test Plan:
- Reset and single write:
  - Stimulus: reset, then push result=0x5A, rd=3, wr_en=1, flag_en=1, flags=4'b0000, with rf_grant tied to 1.
  - Required response: rf_we=1, waddr=3, wdata=0x5A in the next cycle; status=0 after retire; retire_cnt=1; pending_mask bit3 high for exactly one cycle.
- Backpressure:
  - Stimulus: rf_grant=0 while pushing 3 wr_en entries with DEPTH=2.
  - Required response: in_ready=0 after 2 accepts; the third entry is held off; rf_we stays 1 with stable head data; after grant pulses, writes arrive in push order.
- Flag commit order:
  - Stimulus: push SUB 0x05-0x05 (flags Z=1, C=1, i.e. 4'b0011, flag_en=1), then an entry with flag_en=0 and flags=4'b1000.
  - Required response: status=4'b0011 after the first retire and still 4'b0011 after the second; flags_busy high until the first entry retires.
- Condition table:
  - Stimulus: force status via retired entries to N=1, V=0, then N=1, V=1, Z=0; sweep cond_sel 0-15.
  - Required response with N=1, V=0: LT=1, GE=0, LE=1.
  - Required response with N=1, V=1, Z=0: GE=1, GT=1.
  - Required response in both cases: codes 13-15 give 0.
- Non-writing entry and full-queue push/pop:
  - Stimulus (non-writing): push an entry with wr_en=0 and rf_grant=0.
  - Required response: it retires the next edge and rf_we never asserts.
  - Stimulus (full queue): with the queue full, grant and push in the same cycle.
  - Required response: the push is refused (in_ready=0) and count drops to 1.
- Reset mid-operation and counter wrap:
  - Stimulus: assert rst_n=0 while the head waits for grant.
  - Required response: rf_we drops immediately (asynchronously); queue empty; retire_cnt=0.
  - Stimulus: preload via 65536 retires.
  - Required response: retire_cnt wraps to 0.
